// File: rtl/bsr_pkg.sv
// Shared types and instruction decode for the boundary-scan register engine.
// Macro BSR_CLAMP_EN enables the CLAMP instruction; without it code 011 decodes as BYPASS.
package bsr_pkg;

  typedef enum logic [2:0] {
    EXTEST         = 3'b000,
    SAMPLE_PRELOAD = 3'b001,
    INTEST         = 3'b010,
    CLAMP          = 3'b011,
    BYPASS         = 3'b111
  } bsr_instr_t;

  typedef struct packed {
    logic boundary;  // scan through the boundary chain instead of the bypass bit
    logic drive_ur;  // p_o driven from the update latches instead of p_i
  } bsr_sel_t;

  // Unknown codes fall back to BYPASS so a bad IR load can never drive pins.
  function automatic bsr_instr_t legalize_instr(logic [2:0] code);
    bsr_instr_t instr;
    case (code)
      3'b000:  instr = EXTEST;
      3'b001:  instr = SAMPLE_PRELOAD;
      3'b010:  instr = INTEST;
`ifdef BSR_CLAMP_EN
      3'b011:  instr = CLAMP;
`endif
      default: instr = BYPASS;
    endcase
    return instr;
  endfunction

  function automatic bsr_sel_t decode_instr(bsr_instr_t instr);
    bsr_sel_t sel;
    sel.boundary = (instr == EXTEST) || (instr == SAMPLE_PRELOAD) || (instr == INTEST);
    sel.drive_ur = (instr == EXTEST) || (instr == INTEST) || (instr == CLAMP);
    return sel;
  endfunction

endpackage

// File: rtl/bsr_cell.sv
// One boundary-scan cell: a shift/capture stage, an update latch and the pin mux.
module bsr_cell
  import bsr_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic capture,
  input  logic shift,
  input  logic update,
  input  logic si,
  input  logic pi,
  input  logic drive_ur,
  output logic so,
  output logic po
);

  logic sr;
  logic ur;

  // NOTE: registers use non-blocking assignments so every cell samples its
  // neighbour's pre-edge value; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= 1'b0;
      ur <= 1'b0;
    end else begin
      if (capture)     sr <= pi;
      else if (shift)  sr <= si;
      if (update)      ur <= sr;
    end
  end

  assign so = sr;
  assign po = drive_ur ? ur : pi;

endmodule

// File: rtl/bsr_engine.sv
// Boundary-scan register engine: IR, bypass bit, shift counter and a chain of bsr_cell.
// Macro BSR_CLAMP_EN enables the CLAMP instruction (see bsr_pkg).
module bsr_engine
  import bsr_pkg::*;
#(
  parameter int CHAIN_LENGTH = 8,
  parameter int CNT_W        = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    update_ir,
  input  logic [2:0]              instr_i,
  input  logic                    capture_dr,
  input  logic                    shift_dr,
  input  logic                    update_dr,
  input  logic                    tdi,
  input  logic [CHAIN_LENGTH-1:0] p_i,
  output logic [CHAIN_LENGTH-1:0] p_o,
  output logic                    tdo,
  output logic [CNT_W-1:0]        shift_cnt,
  output logic                    length_ok
);

  bsr_instr_t              ir;
  bsr_sel_t                sel;
  logic                    byp;
  logic [CHAIN_LENGTH-1:0] sr;
  logic [CHAIN_LENGTH-1:0] chain_in;
  logic                    do_cap;
  logic                    do_shf;
  logic                    do_upd;

  // Only the highest-priority strobe acts: capture > shift > update.
  assign do_cap = enable & capture_dr;
  assign do_shf = enable & shift_dr & ~capture_dr;
  assign do_upd = enable & update_dr & ~capture_dr & ~shift_dr;

  assign sel      = decode_instr(ir);
  assign chain_in = {sr[CHAIN_LENGTH-2:0], tdi};
  assign tdo      = sel.boundary ? sr[CHAIN_LENGTH-1] : byp;

  for (genvar i = 0; i < CHAIN_LENGTH; i++) begin : g_cell
    bsr_cell u_cell (
      .clk      (clk),
      .rst      (rst),
      .capture  (do_cap & sel.boundary),
      .shift    (do_shf & sel.boundary),
      .update   (do_upd & sel.boundary),
      .si       (chain_in[i]),
      .pi       (p_i[i]),
      .drive_ur (sel.drive_ur),
      .so       (sr[i]),
      .po       (p_o[i])
    );
  end

  // ir is written with <=, so a DR strobe in the same cycle as update_ir
  // still sees the instruction that was active before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir        <= BYPASS;
      byp       <= 1'b0;
      shift_cnt <= '0;
      length_ok <= 1'b0;
    end else begin
      if (enable & update_ir) ir <= legalize_instr(instr_i);
      if (do_cap) begin
        shift_cnt <= '0;
        if (!sel.boundary) byp <= 1'b0;
      end else if (do_shf) begin
        if (shift_cnt != '1) shift_cnt <= shift_cnt + 1'b1;
        if (!sel.boundary) byp <= tdi;
      end else if (do_upd) begin
        length_ok <= (shift_cnt == CNT_W'(CHAIN_LENGTH));
      end
    end
  end

endmodule

// File: tb/tb_bsr_engine.sv
// Self-checking bench for bsr_engine: directed scenarios plus randomized traffic vs a behavioural model.
module tb_bsr_engine;

  localparam int N  = 8;
  localparam int CW = 9;
`ifdef BSR_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, enable, update_ir, capture_dr, shift_dr, update_dr, tdi;
  logic [2:0]    instr_i;
  logic [N-1:0]  p_i, p_o;
  logic          tdo, length_ok;
  logic [CW-1:0] shift_cnt;

  int checks = 0;
  int errors = 0;

  // Behavioural model state: instruction as an integer code, register contents as plain vectors.
  int           m_ir;
  logic [N-1:0] m_sr, m_ur;
  logic         m_byp, m_len;
  int           m_cnt;

  always #5 clk = ~clk;

  bsr_engine #(.CHAIN_LENGTH(N), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .update_ir  (update_ir),
    .instr_i    (instr_i),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .tdi        (tdi),
    .p_i        (p_i),
    .p_o        (p_o),
    .tdo        (tdo),
    .shift_cnt  (shift_cnt),
    .length_ok  (length_ok)
  );

  function automatic int legal(input logic [2:0] c);
    if (c == 3'd0 || c == 3'd1 || c == 3'd2) return int'(c);
    if (c == 3'd3 && CLAMP_EN) return 3;
    return 7;
  endfunction

  function automatic bit m_bnd();
    return (m_ir == 0) || (m_ir == 1) || (m_ir == 2);
  endfunction

  function automatic logic exp_tdo();
    return m_bnd() ? m_sr[N-1] : m_byp;
  endfunction

  function automatic logic [N-1:0] exp_po();
    return ((m_ir == 0) || (m_ir == 2) || (m_ir == 3)) ? m_ur : p_i;
  endfunction

  task automatic model_step();
    int nir;
    if (rst) begin
      m_ir = 7; m_sr = '0; m_ur = '0; m_byp = 1'b0; m_cnt = 0; m_len = 1'b0;
    end else if (enable) begin
      nir = update_ir ? legal(instr_i) : m_ir;
      if (capture_dr) begin
        if (m_bnd()) m_sr = p_i; else m_byp = 1'b0;
        m_cnt = 0;
      end else if (shift_dr) begin
        if (m_bnd()) m_sr = {m_sr[N-2:0], tdi}; else m_byp = tdi;
        if (m_cnt < (1 << CW) - 1) m_cnt++;
      end else if (update_dr) begin
        if (m_bnd()) m_ur = m_sr;
        m_len = (m_cnt == N);
      end
      m_ir = nir;
    end
  endtask

  task automatic set_in(input logic r, input logic en, input logic uir, input logic [2:0] ins,
                        input logic cap, input logic shf, input logic upd, input logic t,
                        input logic [N-1:0] pi);
    rst = r; enable = en; update_ir = uir; instr_i = ins;
    capture_dr = cap; shift_dr = shf; update_dr = upd; tdi = t; p_i = pi;
    #1;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_ir(input logic [2:0] code);
    set_in(0, 1, 1, code, 0, 0, 0, 0, p_i);
    step();
  endtask

  task automatic test_reset();
    set_in(1, 1, 1, 3'd0, 1, 1, 1, 1, 8'hFF);
    step();
    step();
    set_in(0, 0, 0, 3'd0, 0, 0, 0, 0, 8'hA5);
    checks++; if (p_o !== 8'hA5) begin errors++; $display("FAIL reset_p_o got %h exp a5", p_o); end
    checks++; if (tdo !== 1'b0) begin errors++; $display("FAIL reset_tdo got %b exp 0", tdo); end
    checks++; if (shift_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", shift_cnt); end
    checks++; if (length_ok !== 1'b0) begin errors++; $display("FAIL reset_len got %b exp 0", length_ok); end
    step();
  endtask

  task automatic test_sample_preload();
    logic [7:0] data    = 8'h81;
    logic [7:0] exp_seq = 8'b0011_1100;
    load_ir(3'd1);
    set_in(0, 1, 0, 3'd0, 1, 0, 0, 0, 8'h3C);
    step();
    checks++; if (shift_cnt !== '0) begin errors++; $display("FAIL sp_cap_cnt got %0d exp 0", shift_cnt); end
    for (int k = 0; k < 8; k++) begin
      set_in(0, 1, 0, 3'd0, 0, 1, 0, data[k], 8'h3C);
      checks++;
      if (tdo !== exp_seq[k]) begin errors++; $display("FAIL sp_tdo[%0d] got %b exp %b", k, tdo, exp_seq[k]); end
      step();
    end
    checks++; if (shift_cnt !== CW'(8)) begin errors++; $display("FAIL sp_cnt got %0d exp 8", shift_cnt); end
    set_in(0, 1, 0, 3'd0, 0, 0, 1, 0, 8'h5A);
    step();
    checks++; if (length_ok !== 1'b1) begin errors++; $display("FAIL sp_len got %b exp 1", length_ok); end
    checks++; if (p_o !== 8'h5A) begin errors++; $display("FAIL sp_p_o got %h exp 5a", p_o); end
  endtask

  task automatic test_extest();
    logic [N-1:0] r = N'($urandom);
    set_in(0, 1, 1, 3'd0, 0, 0, 0, 0, r);
    step();
    set_in(0, 0, 0, 3'd0, 0, 0, 0, 0, ~r);
    checks++; if (p_o !== 8'h81) begin errors++; $display("FAIL ex_p_o got %h exp 81", p_o); end
    set_in(0, 1, 0, 3'd0, 1, 0, 0, 0, r);
    step();
    for (int k = 0; k < 7; k++) begin
      set_in(0, 1, 0, 3'd0, 0, 1, 0, 1'($urandom), r);
      step();
    end
    set_in(0, 1, 0, 3'd0, 0, 0, 1, 0, r);
    step();
    checks++; if (length_ok !== 1'b0) begin errors++; $display("FAIL ex_len7 got %b exp 0", length_ok); end
    checks++; if (p_o !== m_ur) begin errors++; $display("FAIL ex_p_o_upd got %h exp %h", p_o, m_ur); end
  endtask

  task automatic test_bypass();
    logic [N-1:0] saved = m_ur;
    logic [2:0]   bits  = 3'b101;
    logic [2:0]   exp_o = 3'b010;
    load_ir(3'd7);
    set_in(0, 1, 0, 3'd0, 1, 0, 0, 0, ~saved);
    step();
    for (int k = 0; k < 3; k++) begin
      set_in(0, 1, 0, 3'd0, 0, 1, 0, bits[k], ~saved);
      checks++;
      if (tdo !== exp_o[k]) begin errors++; $display("FAIL byp_tdo[%0d] got %b exp %b", k, tdo, exp_o[k]); end
      step();
    end
    set_in(0, 1, 0, 3'd0, 0, 0, 1, 0, ~saved);
    step();
    checks++; if (p_o !== ~saved) begin errors++; $display("FAIL byp_p_o got %h exp %h", p_o, ~saved); end
    load_ir(3'd0);
    checks++; if (p_o !== saved) begin errors++; $display("FAIL byp_ur_kept got %h exp %h", p_o, saved); end
  endtask

  task automatic test_priority();
    logic [N-1:0] r = N'($urandom);
    logic [N-1:0] got;
    logic [N-1:0] snap_po;
    logic         snap_tdo;
    logic [CW-1:0] snap_cnt;
    set_in(0, 1, 0, 3'd0, 1, 1, 1, ~r[0], r);
    step();
    checks++; if (shift_cnt !== '0) begin errors++; $display("FAIL pri_cnt got %0d exp 0", shift_cnt); end
    got = '0;
    for (int k = 0; k < N; k++) begin
      set_in(0, 1, 0, 3'd0, 0, 1, 0, 0, r);
      got = {got[N-2:0], tdo};
      step();
    end
    checks++; if (got !== r) begin errors++; $display("FAIL pri_sr got %h exp %h", got, r); end
    snap_po = p_o; snap_tdo = tdo; snap_cnt = shift_cnt;
    set_in(0, 0, 1, 3'd7, 1, 1, 1, 1, r);
    step();
    set_in(0, 0, 0, 3'd0, 0, 0, 0, 0, r);
    checks++;
    if (p_o !== snap_po || tdo !== snap_tdo || shift_cnt !== snap_cnt) begin
      errors++;
      $display("FAIL en0_hold got %h/%b/%0d exp %h/%b/%0d", p_o, tdo, shift_cnt, snap_po, snap_tdo, snap_cnt);
    end
    checks++; if (p_o !== m_ur) begin errors++; $display("FAIL en0_ir_kept got %h exp %h", p_o, m_ur); end
  endtask

  task automatic test_back_to_back();
    load_ir(3'd7);
    set_in(0, 1, 0, 3'd0, 1, 0, 0, 0, p_i);
    step();
    set_in(0, 1, 1, 3'd0, 0, 1, 0, 1, p_i);
    checks++; if (tdo !== 1'b0) begin errors++; $display("FAIL b2b_tdo_pre got %b exp 0", tdo); end
    step();
    checks++; if (tdo !== exp_tdo()) begin errors++; $display("FAIL b2b_tdo_post got %b exp %b", tdo, exp_tdo()); end
    checks++; if (shift_cnt !== CW'(1)) begin errors++; $display("FAIL b2b_cnt got %0d exp 1", shift_cnt); end
    load_ir(3'd7);
    checks++; if (tdo !== 1'b1) begin errors++; $display("FAIL b2b_byp got %b exp 1", tdo); end
  endtask

  task automatic test_clamp();
    load_ir(3'd3);
    set_in(0, 0, 0, 3'd0, 0, 0, 0, 0, ~m_ur);
    checks++; if (p_o !== exp_po()) begin errors++; $display("FAIL clamp_p_o got %h exp %h", p_o, exp_po()); end
    set_in(0, 1, 0, 3'd0, 1, 0, 0, 0, p_i);
    step();
    checks++; if (tdo !== 1'b0) begin errors++; $display("FAIL clamp_tdo_cap got %b exp 0", tdo); end
    set_in(0, 1, 0, 3'd0, 0, 1, 0, 1, p_i);
    step();
    checks++; if (tdo !== 1'b1) begin errors++; $display("FAIL clamp_tdo_shift got %b exp 1", tdo); end
  endtask

  task automatic test_reset_mid();
    load_ir(3'd0);
    set_in(0, 1, 0, 3'd0, 1, 0, 0, 0, 8'hC3);
    step();
    for (int k = 0; k < 3; k++) begin
      set_in(0, 1, 0, 3'd0, 0, 1, 0, 1, 8'hC3);
      step();
    end
    set_in(1, 1, 0, 3'd0, 0, 0, 1, 1, 8'h66);
    step();
    set_in(0, 0, 0, 3'd0, 0, 0, 0, 0, 8'h66);
    checks++; if (p_o !== 8'h66) begin errors++; $display("FAIL rmid_p_o got %h exp 66", p_o); end
    checks++; if (shift_cnt !== '0 || length_ok !== 1'b0 || tdo !== 1'b0) begin
      errors++; $display("FAIL rmid_state got %0d/%b/%b exp 0/0/0", shift_cnt, length_ok, tdo);
    end
    load_ir(3'd0);
    checks++; if (p_o !== 8'h00) begin errors++; $display("FAIL rmid_ur got %h exp 00", p_o); end
  endtask

  task automatic test_saturation();
    load_ir(3'd1);
    set_in(0, 1, 0, 3'd0, 1, 0, 0, 0, p_i);
    step();
    for (int k = 0; k < 515; k++) begin
      set_in(0, 1, 0, 3'd0, 0, 1, 0, 1'($urandom), p_i);
      step();
    end
    checks++; if (shift_cnt !== CW'(511)) begin errors++; $display("FAIL sat_cnt got %0d exp 511", shift_cnt); end
    set_in(0, 1, 0, 3'd0, 0, 0, 1, 0, p_i);
    step();
    checks++; if (length_ok !== 1'b0 || shift_cnt !== CW'(511)) begin
      errors++; $display("FAIL sat_hold got %b/%0d exp 0/511", length_ok, shift_cnt);
    end
    set_in(0, 1, 0, 3'd0, 1, 0, 0, 0, p_i);
    step();
    checks++; if (shift_cnt !== '0) begin errors++; $display("FAIL sat_clear got %0d exp 0", shift_cnt); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      set_in(($urandom % 60) == 0, ($urandom % 8) != 0, ($urandom % 6) == 0, 3'($urandom),
             ($urandom % 12) == 0, ($urandom % 3) != 0, ($urandom % 5) == 0, 1'($urandom), N'($urandom));
      checks++; if (tdo !== exp_tdo()) begin errors++; $display("FAIL rnd_tdo[%0d] got %b exp %b", n, tdo, exp_tdo()); end
      checks++; if (p_o !== exp_po()) begin errors++; $display("FAIL rnd_p_o[%0d] got %h exp %h", n, p_o, exp_po()); end
      step();
      checks++; if (shift_cnt !== CW'(m_cnt)) begin errors++; $display("FAIL rnd_cnt[%0d] got %0d exp %0d", n, shift_cnt, m_cnt); end
      checks++; if (length_ok !== m_len) begin errors++; $display("FAIL rnd_len[%0d] got %b exp %b", n, length_ok, m_len); end
    end
  endtask

  initial begin
    test_reset();
    test_sample_preload();
    test_extest();
    test_bypass();
    test_priority();
    test_back_to_back();
    test_clamp();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
